// File: rtl/gpr_file_scb.sv
// Multi-ported general-purpose register file with an issue scoreboard (busy bit per register).
// Optional macro GPR_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module gpr_file_scb #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM     = 32,
  parameter int READ_PORTS  = 4,
  parameter int WRITE_PORTS = 2,
  parameter int ISSUE_PORTS = 2,
  localparam int AW = $clog2(REG_NUM),
  localparam int CW = $clog2(REG_NUM + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [READ_PORTS-1:0][AW-1:0]          r_addr_i,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  r_data_o,
  output logic [READ_PORTS-1:0]                  r_busy_o,
  input  logic [WRITE_PORTS-1:0][AW-1:0]         w_addr_i,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] w_data_i,
  input  logic [WRITE_PORTS-1:0]                 w_en_i,
  input  logic [ISSUE_PORTS-1:0][AW-1:0]         set_addr_i,
  input  logic [ISSUE_PORTS-1:0]                 set_en_i,
  output logic [CW-1:0]                          busy_cnt_o,
  output logic                                   conflict_o
);

  logic [DATA_WIDTH-1:0] regs   [REG_NUM];
  logic [DATA_WIDTH-1:0] wr_val [REG_NUM];
  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_d;
  logic [REG_NUM-1:0]    wr_hit;
  logic [REG_NUM-1:0]    set_hit;
  logic [CW-1:0]         busy_cnt_q;
  logic [CW-1:0]         busy_cnt_d;

  // Register 0 and out-of-range addresses are never stored, marked busy or read back.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < REG_NUM);
  endfunction

  // Write/set decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int j = 0; j < REG_NUM; j++) wr_val[j] = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      if (w_en_i[k] && addr_ok(w_addr_i[k])) begin
        wr_hit[w_addr_i[k]] = 1'b1;
        wr_val[w_addr_i[k]] = w_data_i[k];
      end
    end
    for (int s = 0; s < ISSUE_PORTS; s++) begin
      if (set_en_i[s] && addr_ok(set_addr_i[s])) set_hit[set_addr_i[s]] = 1'b1;
    end
  end

  // A set in the same cycle as a writeback keeps the register busy.
  always_comb begin
    busy_d     = set_hit | (busy_q & ~wr_hit);
    busy_d[0]  = 1'b0;
    busy_cnt_d = '0;
    for (int j = 0; j < REG_NUM; j++) busy_cnt_d = busy_cnt_d + CW'(busy_d[j]);
  end

  always_comb begin
    conflict_o = 1'b0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      for (int m = k + 1; m < WRITE_PORTS; m++) begin
        if (w_en_i[k] && w_en_i[m] && (w_addr_i[k] == w_addr_i[m]) && (w_addr_i[k] != '0))
          conflict_o = 1'b1;
      end
    end
  end

  always_comb begin
    r_data_o = '0;
    r_busy_o = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if (addr_ok(r_addr_i[i])) begin
        r_data_o[i] = regs[r_addr_i[i]];
        r_busy_o[i] = busy_q[r_addr_i[i]];
      end
`ifdef GPR_BYPASS_EN
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (w_en_i[k] && addr_ok(w_addr_i[k]) && (w_addr_i[k] == r_addr_i[i]))
          r_data_o[i] = w_data_i[k];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < REG_NUM; j++) regs[j] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int j = 0; j < REG_NUM; j++) begin
        if (wr_hit[j]) regs[j] <= wr_val[j];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

endmodule
